// File: rtl/l2_responder_pkg.sv
// Shared bus-controller types: address/data words and the responder status seen by the coherence controller.
// No latency or backpressure of its own; the types are consumed by l2_responder and the controller.
package l2_responder_pkg;

  typedef logic [31:0] word_t;
  typedef logic [63:0] longWord_t;

  typedef enum logic [1:0] {
    L2_FREE   = 2'b00,
    L2_BUSY   = 2'b01,
    L2_ACCESS = 2'b10,
    L2_ERROR  = 2'b11
  } l2_state_t;

  localparam int unsigned WORD_OFS_W = 3;

endpackage

// File: rtl/l2_sram.sv
// Single-port DEPTH x 64 storage; write and read both registered, read returns pre-write contents.
// One-cycle read latency, no backpressure; contents are never cleared.
module l2_sram
  import l2_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  longWord_t        wdat_i,
  output longWord_t        rdat_o
);

  longWord_t mem_q [DEPTH];
  longWord_t rdat_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdat_i;
    end
    rdat_q <= mem_q[idx_i];
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/l2_responder.sv
// L2 storage responder: LATENCY busy cycles per access, then one ACCESS or ERROR cycle, then FREE.
// Requests are level-held by the controller; dropping both enables while busy aborts the access.
module l2_responder
  import l2_responder_pkg::*;
#(
  parameter int    LATENCY   = 4,
  parameter int    DEPTH     = 256,
  parameter word_t BASE_ADDR = 32'h0000_0000
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      l2REN,
  input  logic      l2WEN,
  input  word_t     l2addr,
  input  longWord_t l2store,
  output l2_state_t l2state,
  output longWord_t l2load
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [63:0] SPAN = 64'(DEPTH) << WORD_OFS_W;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10,
    FAIL = 2'b11
  } fsm_e;

  fsm_e             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_wr_q, op_wr_d;
  word_t            addr_q, addr_d;
  longWord_t        data_q, data_d;
  longWord_t        load_q, load_d;

  word_t            req_ofs;
  word_t            lat_ofs;
  logic             req_bad;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] lat_idx;
  logic [IDX_W-1:0] sram_idx;
  logic             sram_we;
  longWord_t        sram_rdat;

  assign req_ofs = l2addr - BASE_ADDR;
  assign lat_ofs = addr_q - BASE_ADDR;
  assign req_bad = (l2addr[WORD_OFS_W-1:0] != '0) || ({32'h0, req_ofs} >= SPAN);
  assign req_idx = IDX_W'(req_ofs >> WORD_OFS_W);
  assign lat_idx = IDX_W'(lat_ofs >> WORD_OFS_W);

  // The incoming index is presented while idle so read data is ready even when LATENCY is 1.
  assign sram_idx = (state_q == IDLE) ? req_idx : lat_idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    load_d  = load_q;
    sram_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (l2REN && l2WEN) begin
          state_d = FAIL;
        end else if (l2REN || l2WEN) begin
          if (req_bad) begin
            state_d = FAIL;
          end else begin
            state_d = BUSY;
            op_wr_d = l2WEN;
            addr_d  = l2addr;
            data_d  = l2store;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (!l2REN && !l2WEN) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
          sram_we = op_wr_q;
          if (!op_wr_q) begin
            load_d = sram_rdat;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      load_q  <= load_d;
    end
  end

  // Reset must also suppress a commit that would otherwise land on the same edge.
  l2_sram #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_sram (
    .clk_i (CLK),
    .we_i  (sram_we && !RST),
    .idx_i (sram_idx),
    .wdat_i(data_q),
    .rdat_o(sram_rdat)
  );

  always_comb begin
    l2state = L2_FREE;
    case (state_q)
      IDLE:    l2state = L2_FREE;
      BUSY:    l2state = L2_BUSY;
      DONE:    l2state = L2_ACCESS;
      FAIL:    l2state = L2_ERROR;
      default: l2state = L2_FREE;
    endcase
  end

  assign l2load = load_q;

endmodule

// File: tb/tb_l2_responder.sv
// Bench for l2_responder: a LATENCY=4 and a LATENCY=1 instance checked every cycle against a transaction-level model.
module tb_l2_responder;
  import l2_responder_pkg::*;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [1:0]       ren = '0;
  logic [1:0]       wen = '0;
  logic [1:0][31:0] addr = '0;
  logic [1:0][63:0] store = '0;
  l2_state_t        st0, st1;
  logic [63:0]      ld0, ld1;

  int checks   = 0;
  int failures = 0;

  logic [1:0]  exp_vld = '0;
  l2_state_t   exp_state [2];
  logic [63:0] exp_load  [2];
  logic [63:0] mem_m     [2][256];

  always #5 CLK = ~CLK;

  l2_responder #(.LATENCY(4), .DEPTH(256), .BASE_ADDR(32'h0)) u_dut0 (
    .CLK(CLK), .RST(RST), .l2REN(ren[0]), .l2WEN(wen[0]), .l2addr(addr[0]),
    .l2store(store[0]), .l2state(st0), .l2load(ld0));

  l2_responder #(.LATENCY(1), .DEPTH(256), .BASE_ADDR(32'h0)) u_dut1 (
    .CLK(CLK), .RST(RST), .l2REN(ren[1]), .l2WEN(wen[1]), .l2addr(addr[1]),
    .l2store(store[1]), .l2state(st1), .l2load(ld1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (exp_vld[i]) begin
        chk($sformatf("dut%0d.l2state", i), {62'h0, (i == 0) ? st0 : st1}, {62'h0, exp_state[i]});
        chk($sformatf("dut%0d.l2load", i), (i == 0) ? ld0 : ld1, exp_load[i]);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One request on instance s, starting in a FREE cycle and returning in a FREE cycle.
  // abort_k > 0 drops both enables during that BUSY cycle; hold keeps the request asserted.
  task automatic do_access(input int s, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [63:0] d, input int abort_k, input bit hold);
    int lat;
    bit bad;
    int idx;
    lat = (s == 0) ? 4 : 1;
    bad = (rd && wr) || (a % 8 != 0) || (a >= 32'h800);
    idx = int'(a / 8);
    ren[s] = rd; wen[s] = wr; addr[s] = a; store[s] = d;
    tick();
    if (bad) begin
      exp_state[s] = L2_ERROR;
      if (!hold) begin ren[s] = 1'b0; wen[s] = 1'b0; end
      tick();
      exp_state[s] = L2_FREE;
      return;
    end
    for (int b = 1; b <= lat; b++) begin
      exp_state[s] = L2_BUSY;
      if (b == abort_k) begin
        ren[s] = 1'b0; wen[s] = 1'b0;
        tick();
        exp_state[s] = L2_FREE;
        return;
      end
      if (!hold) begin
        addr[s]  = $urandom;
        store[s] = {$urandom, $urandom};
      end
      tick();
    end
    if (wr) mem_m[s][idx] = d;
    else    exp_load[s] = mem_m[s][idx];
    exp_state[s] = L2_ACCESS;
    if (!hold) begin ren[s] = 1'b0; wen[s] = 1'b0; end
    tick();
    exp_state[s] = L2_FREE;
  endtask

  initial begin
    int s, k, idx;
    logic [31:0] a;
    tick();
    for (int i = 0; i < 2; i++) begin
      exp_state[i] = L2_FREE;
      exp_load[i]  = 64'h0;
    end
    exp_vld = 2'b11;
    tick();
    RST = 1'b0;
    chk("reset_state0", {62'h0, st0}, {62'h0, L2_FREE});
    chk("reset_load0", ld0, 64'h0);
    chk("reset_state1", {62'h0, st1}, {62'h0, L2_FREE});

    for (int i = 0; i < 16; i++) begin
      do_access(0, 1'b0, 1'b1, 32'(i * 8), 64'hA5A5_0000_0000_0000 | 64'(i), 0, 1'b0);
      do_access(1, 1'b0, 1'b1, 32'(i * 8), 64'hA5A5_0000_0000_0000 | 64'(i), 0, 1'b0);
    end

    do_access(0, 1'b0, 1'b1, 32'h40, 64'hDEAD_BEEF_0123_4567, 0, 1'b0);
    do_access(0, 1'b1, 1'b0, 32'h40, 64'h0, 0, 1'b0);
    chk("write_read_0x40", ld0, 64'hDEAD_BEEF_0123_4567);

    do_access(0, 1'b1, 1'b0, 32'h4, 64'h0, 0, 1'b0);
    do_access(0, 1'b1, 1'b0, 32'h800, 64'h0, 0, 1'b0);
    do_access(0, 1'b1, 1'b1, 32'h40, 64'h0, 0, 1'b0);
    chk("errors_keep_load", ld0, 64'hDEAD_BEEF_0123_4567);
    do_access(0, 1'b1, 1'b0, 32'h40, 64'h0, 0, 1'b0);

    do_access(0, 1'b0, 1'b1, 32'h10, 64'h1, 2, 1'b0);
    do_access(0, 1'b1, 1'b0, 32'h10, 64'h0, 0, 1'b0);
    chk("abort_keeps_old", ld0, 64'hA5A5_0000_0000_0002);

    ren[0] = 1'b0; wen[0] = 1'b1; addr[0] = 32'h18; store[0] = 64'hFFFF;
    tick();
    exp_state[0] = L2_BUSY;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0; wen[0] = 1'b0;
    exp_state[0] = L2_FREE;
    exp_load[0] = 64'h0;
    exp_load[1] = 64'h0;
    chk("rst_mid_state", {62'h0, st0}, {62'h0, L2_FREE});
    chk("rst_mid_load", ld0, 64'h0);
    do_access(0, 1'b1, 1'b0, 32'h18, 64'h0, 0, 1'b0);
    chk("rst_no_commit", ld0, 64'hA5A5_0000_0000_0003);

    for (int r = 0; r < 3; r++) do_access(0, 1'b1, 1'b0, 32'h8, 64'h0, 0, 1'b1);
    ren[0] = 1'b0;
    chk("hold_read_load", ld0, 64'hA5A5_0000_0000_0001);

    do_access(1, 1'b1, 1'b0, 32'h18, 64'h0, 0, 1'b0);
    chk("lat1_read", ld1, 64'hA5A5_0000_0000_0003);

    for (int n = 0; n < 80; n++) begin
      s   = int'($urandom_range(0, 1));
      k   = int'($urandom_range(0, 9));
      idx = int'($urandom_range(0, 15));
      a   = 32'(idx * 8);
      if (k < 4)
        do_access(s, 1'b1, 1'b0, a, 64'h0, 0, 1'b0);
      else if (k < 7)
        do_access(s, 1'b0, 1'b1, a, {$urandom, $urandom}, 0, 1'b0);
      else if (k == 7 && s == 0)
        do_access(s, k[0] ^ n[0], !(k[0] ^ n[0]), a, {$urandom, $urandom},
                  int'($urandom_range(1, 3)), 1'b0);
      else if (k == 7)
        do_access(s, 1'b1, 1'b0, a, 64'h0, 0, 1'b0);
      else if (k == 8)
        do_access(s, 1'b1, 1'b0, a | 32'($urandom_range(1, 7)), 64'h0, 0, 1'b0);
      else if (n % 2 == 0)
        do_access(s, 1'b1, 1'b0, 32'h800 + 32'(idx * 8), 64'h0, 0, 1'b0);
      else
        do_access(s, 1'b1, 1'b1, a, {$urandom, $urandom}, 0, 1'b0);
    end

    for (int i = 0; i < 16; i++) do_access(0, 1'b1, 1'b0, 32'(i * 8), 64'h0, 0, 1'b0);
    tick();
    exp_vld = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
